// File: rtl/linescanner_line_buffer.sv
// Frames captured pixels into first/last-marked lines and buffers them in a FWFT FIFO.
// Optional statistics outputs: define LINESCANNER_LINE_BUFFER_STATS_EN.
module linescanner_line_buffer #(
    parameter int DEPTH       = 16,
    parameter int LINE_PIXELS = 1024
) (
    input  logic        main_clock,
    input  logic        n_reset,
    input  logic        enable,
    input  logic        lval,
    input  logic [7:0]  pixel_data,
    input  logic        pixel_captured,
    output logic [7:0]  m_data,
    output logic        m_first,
    output logic        m_last,
    output logic        m_valid,
    input  logic        m_ready,
    output logic        overflow,
    output logic [15:0] line_count,
    output logic [15:0] last_line_length
);

    localparam int          AW       = $clog2(DEPTH);
    localparam logic [15:0] LAST_IDX = 16'(LINE_PIXELS - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        TRUNC
    } state_t;

    state_t      state;
    logic        lval_q;
    logic        hold_valid;
    logic        hold_first;
    logic        hold_flush;
    logic [7:0]  hold_data;
    logic [15:0] pix_cnt;

    logic        line_end;
    logic        accept;
    logic        wr_en;
    logic        wr_last;

    logic [AW:0] wptr;
    logic [AW:0] rptr;
    logic [9:0]  mem [DEPTH];
    logic [9:0]  rd_word;
    logic        full;
    logic        empty;
    logic        rd_en;

    assign line_end = lval_q & ~lval;
    assign accept   = pixel_captured & lval & enable & (state != TRUNC);

    // The held pixel leaves on the next accept, the line end, or a truncation flush.
    always_comb begin
        wr_en   = 1'b0;
        wr_last = 1'b0;
        if (enable) begin
            case (state)
                ACTIVE: begin
                    if (accept) begin
                        wr_en   = hold_valid;
                        wr_last = 1'b0;
                    end else if (line_end) begin
                        wr_en   = hold_valid;
                        wr_last = 1'b1;
                    end
                end
                TRUNC: begin
                    if (hold_valid && hold_flush) begin
                        wr_en   = 1'b1;
                        wr_last = 1'b1;
                    end
                end
                default: begin
                    wr_en   = 1'b0;
                    wr_last = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge main_clock or negedge n_reset) begin
        if (!n_reset) begin
            state      <= IDLE;
            lval_q     <= 1'b0;
            hold_valid <= 1'b0;
            hold_first <= 1'b0;
            hold_flush <= 1'b0;
            hold_data  <= '0;
            pix_cnt    <= '0;
        end else begin
            lval_q <= lval;
            if (!enable) begin
                state      <= IDLE;
                hold_valid <= 1'b0;
                hold_flush <= 1'b0;
                pix_cnt    <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (accept) begin
                            hold_valid <= 1'b1;
                            hold_first <= 1'b1;
                            hold_data  <= pixel_data;
                            pix_cnt    <= 16'd1;
                            if (LINE_PIXELS == 1) begin
                                hold_flush <= 1'b1;
                                state      <= TRUNC;
                            end else begin
                                state <= ACTIVE;
                            end
                        end
                    end
                    ACTIVE: begin
                        if (accept) begin
                            hold_data  <= pixel_data;
                            hold_first <= 1'b0;
                            pix_cnt    <= pix_cnt + 16'd1;
                            if (pix_cnt == LAST_IDX) begin
                                hold_flush <= 1'b1;
                                state      <= TRUNC;
                            end
                        end else if (line_end) begin
                            hold_valid <= 1'b0;
                            pix_cnt    <= '0;
                            state      <= IDLE;
                        end
                    end
                    TRUNC: begin
                        if (hold_flush) begin
                            hold_valid <= 1'b0;
                            hold_flush <= 1'b0;
                        end
                        if (line_end) begin
                            pix_cnt <= '0;
                            state   <= IDLE;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) &&
                   (wptr[AW-1:0] == rptr[AW-1:0]);
    assign rd_en = m_valid & m_ready;

    always_ff @(posedge main_clock or negedge n_reset) begin
        if (!n_reset) begin
            wptr     <= '0;
            rptr     <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_en && !full) begin
                wptr <= wptr + 1'b1;
            end
            if (rd_en) begin
                rptr <= rptr + 1'b1;
            end
            overflow <= enable ? (overflow | (wr_en & full)) : 1'b0;
        end
    end

    always_ff @(posedge main_clock) begin
        if (wr_en && !full) begin
            mem[wptr[AW-1:0]] <= {hold_first, wr_last, hold_data};
        end
    end

    // Outputs are gated by m_valid so reset clears them without a clock.
    assign rd_word = mem[rptr[AW-1:0]];
    assign m_valid = ~empty;
    assign m_data  = m_valid ? rd_word[7:0] : 8'd0;
    assign m_last  = m_valid & rd_word[8];
    assign m_first = m_valid & rd_word[9];

`ifdef LINESCANNER_LINE_BUFFER_STATS_EN
    always_ff @(posedge main_clock or negedge n_reset) begin
        if (!n_reset) begin
            line_count       <= '0;
            last_line_length <= '0;
        end else if (wr_en && wr_last) begin
            line_count       <= line_count + 16'd1;
            last_line_length <= pix_cnt;
        end
    end
`else
    assign line_count       = '0;
    assign last_line_length = '0;
`endif

endmodule

// File: tb/tb_linescanner_line_buffer.sv
// Scoreboard bench for linescanner_line_buffer with a line-level reference model.
module tb_linescanner_line_buffer;

    localparam int DEPTH = 16;
    localparam int LP    = 8;

    logic        clk            = 1'b0;
    logic        n_reset        = 1'b0;
    logic        enable         = 1'b0;
    logic        lval           = 1'b0;
    logic [7:0]  pixel_data     = 8'd0;
    logic        pixel_captured = 1'b0;
    logic        m_ready        = 1'b0;
    logic [7:0]  m_data;
    logic        m_first;
    logic        m_last;
    logic        m_valid;
    logic        overflow;
    logic [15:0] line_count;
    logic [15:0] last_line_length;

    always #5 clk = ~clk;

    linescanner_line_buffer #(
        .DEPTH      (DEPTH),
        .LINE_PIXELS(LP)
    ) dut (
        .main_clock      (clk),
        .n_reset         (n_reset),
        .enable          (enable),
        .lval            (lval),
        .pixel_data      (pixel_data),
        .pixel_captured  (pixel_captured),
        .m_data          (m_data),
        .m_first         (m_first),
        .m_last          (m_last),
        .m_valid         (m_valid),
        .m_ready         (m_ready),
        .overflow        (overflow),
        .line_count      (line_count),
        .last_line_length(last_line_length)
    );

    typedef struct packed {
        logic       first;
        logic       last;
        logic [7:0] data;
    } ent_t;

    int   compared   = 0;
    int   mismatched = 0;
    int   popped     = 0;
    int   cyc        = 0;
    int   rdy_mode   = 1;
    ent_t exp_q[$];

    // reference model state: FIFO occupancy, pixels in line, pending pixel
    int         cnt = 0;
    int         n   = 0;
    bit         pend_v = 0;
    bit         pend_first = 0;
    bit         pend_flush = 0;
    logic [7:0] pend_data = 8'd0;
    bit         lv_prev = 0;
    bit         ovf = 0;
    int         lc = 0;
    int         llen = 0;

    task automatic check(input string name, input longint act, input longint exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic longint stat_lc();
`ifdef LINESCANNER_LINE_BUFFER_STATS_EN
        return longint'(lc & 16'hffff);
`else
        return 0;
`endif
    endfunction

    function automatic longint stat_len();
`ifdef LINESCANNER_LINE_BUFFER_STATS_EN
        return longint'(llen & 16'hffff);
`else
        return 0;
`endif
    endfunction

    function automatic bit pick_rdy();
        case (rdy_mode)
            0:       return 1'b0;
            1:       return 1'b1;
            2:       return cyc[0];
            default: return ($urandom_range(0, 9) < 6);
        endcase
    endfunction

    task automatic step(input bit en, input bit lv, input bit pc, input logic [7:0] pd);
        bit   rdy;
        bit   rd;
        bit   w;
        bit   le;
        ent_t e;
        @(posedge clk);
        #1;
        check("m_valid", m_valid, longint'(cnt > 0));
        check("overflow", overflow, longint'(ovf));
        check("line_count", line_count, stat_lc());
        check("last_line_length", last_line_length, stat_len());
        rdy = pick_rdy();
        cyc++;
        enable = en;
        lval = lv;
        pixel_captured = pc;
        pixel_data = pd;
        m_ready = rdy;
        rd = (cnt > 0) && rdy;
        w = 0;
        e = '0;
        le = lv_prev && !lv;
        if (!en) begin
            pend_v = 0;
            pend_flush = 0;
            n = 0;
            ovf = 0;
        end else begin
            if (pend_v && (pend_flush || le)) begin
                w = 1;
                e = '{pend_first, 1'b1, pend_data};
                lc++;
                llen = n;
                pend_v = 0;
                pend_flush = 0;
            end
            if (pc && lv && n < LP) begin
                if (pend_v) begin
                    w = 1;
                    e = '{pend_first, 1'b0, pend_data};
                end
                pend_v = 1;
                pend_first = (n == 0);
                pend_data = pd;
                n++;
                pend_flush = (n == LP);
            end
            if (le) n = 0;
        end
        if (w) begin
            if (cnt == DEPTH) ovf = 1;
            else begin
                exp_q.push_back(e);
                cnt++;
            end
        end
        if (rd) cnt--;
        lv_prev = lv;
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) step(1, 0, 0, 8'($urandom));
    endtask

    task automatic send_line(input int len, input int base, input int gap_pct);
        for (int i = 0; i < len; i++) begin
            if ($urandom_range(0, 99) < gap_pct) step(1, 1, 0, 8'($urandom));
            step(1, 1, 1, (base < 0) ? 8'($urandom) : 8'(base + i));
        end
        step(1, 0, 0, 8'd0);
    endtask

    task automatic reset_mid();
        @(posedge clk);
        #3;
        check("pre_reset_valid", m_valid, 1);
        n_reset = 1'b0;
        lval = 1'b0;
        pixel_captured = 1'b0;
        #1;
        check("rst_m_valid", m_valid, 0);
        check("rst_m_data", m_data, 0);
        check("rst_m_first", m_first, 0);
        check("rst_m_last", m_last, 0);
        check("rst_overflow", overflow, 0);
        exp_q.delete();
        cnt = 0; n = 0; pend_v = 0; pend_flush = 0;
        lv_prev = 0; ovf = 0; lc = 0; llen = 0;
        repeat (2) @(posedge clk);
        #3;
        n_reset = 1'b1;
    endtask

    initial begin : monitor
        ent_t e;
        forever begin
            @(negedge clk);
            if (n_reset && m_valid && m_ready) begin
                popped++;
                if (exp_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_output: got data %0d expected none", m_data);
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", m_data, e.data);
                    check("out_first", m_first, e.first);
                    check("out_last", m_last, e.last);
                end
            end
        end
    end

    initial begin : driver
        int run_left;
        bit lv;
        repeat (2) @(posedge clk);
        #1;
        check("reset_m_data", m_data, 0);
        check("reset_m_first", m_first, 0);
        check("reset_m_last", m_last, 0);
        #2;
        n_reset = 1'b1;

        rdy_mode = 1;
        popped = 0;
        send_line(5, 10, 0);
        idle(6);
        check("basic_count", popped, 5);

        popped = 0;
        send_line(12, 0, 0);
        idle(6);
        check("trunc_count", popped, 8);

        rdy_mode = 0;
        popped = 0;
        for (int k = 0; k < 3; k++) send_line(8, 100 + 8 * k, 0);
        idle(2);
        check("ovf_set", overflow, 1);
        check("ovf_valid", m_valid, 1);
        rdy_mode = 1;
        idle(24);
        check("ovf_drain_count", popped, 16);
        check("ovf_sticky", overflow, 1);

        rdy_mode = 2;
        popped = 0;
        send_line(3, 30, 20);
        idle(2);
        send_line(6, 40, 20);
        idle(2);
        send_line(10, 70, 0);
        idle(30);
        check("bp_count", popped, 17);

        rdy_mode = 1;
        popped = 0;
        for (int i = 0; i < 3; i++) step(1, 1, 1, 8'(90 + i));
        step(0, 1, 1, 8'd93);
        step(0, 0, 0, 8'd0);
        step(0, 0, 0, 8'd0);
        idle(2);
        send_line(4, 50, 0);
        idle(6);
        check("en_drop_count", popped, 6);
        check("en_drop_ovf", overflow, 0);

        rdy_mode = 0;
        popped = 0;
        for (int i = 0; i < 4; i++) step(1, 1, 1, 8'(200 + i));
        reset_mid();
        rdy_mode = 1;
        send_line(4, 60, 0);
        idle(6);
        check("post_reset_count", popped, 4);

        rdy_mode = 3;
        lv = 0;
        run_left = 0;
        for (int c = 0; c < 2500; c++) begin
            if (run_left == 0) begin
                lv = !lv;
                run_left = lv ? $urandom_range(1, 20) : $urandom_range(1, 4);
            end
            run_left--;
            if (c % 500 == 250) rdy_mode = (rdy_mode == 3) ? 0 : 3;
            step(($urandom_range(0, 63) != 0), lv,
                 ($urandom_range(0, 2) != 0), 8'($urandom));
        end

        rdy_mode = 1;
        idle(40);
        check("final_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
